// File: rtl/door_sequencer.sv
// rtl/door_sequencer.sv - frame-paced exit door sequencer: lock, row slide animation, exit event
// Build option: define DOOR_AUTOCLOSE_EN to include the OPEN-state hold counter and auto-close.
module door_sequencer #(
    parameter int DOOR_HEIGHT = 80,
    parameter int STEP        = 4,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       unlock,
    input  logic       player_at_door,
    input  logic       close_req,
    output logic [6:0] door_open_rows,
    output logic [2:0] state,
    output logic       locked,
    output logic       exit_pulse
);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_CLOSED  = 3'd1,
        S_OPENING = 3'd2,
        S_OPEN    = 3'd3,
        S_CLOSING = 3'd4,
        S_EXITED  = 3'd5
    } door_state_t;

    localparam logic [7:0] L_HEIGHT = 8'(DOOR_HEIGHT);
    localparam logic [7:0] L_STEP   = 8'(STEP);

    door_state_t r_state;
    door_state_t w_state_nxt;
    logic [6:0]  r_rows;
    logic [6:0]  w_rows_nxt;
    logic        r_exit;
    logic        w_exit_nxt;
    logic        r_locked;

    logic [7:0]  w_rows8;
    logic [7:0]  w_rows_up;
    logic [6:0]  w_rows_dn;
    logic        w_hold_done;

    // Row math is done one bit wider so rows+STEP never wraps before the compare.
    assign w_rows8   = {1'b0, r_rows};
    assign w_rows_up = w_rows8 + L_STEP;
    assign w_rows_dn = r_rows - L_STEP[6:0];

`ifdef DOOR_AUTOCLOSE_EN
    localparam logic [7:0] L_HOLD_LAST = 8'(HOLD_FRAMES - 1);

    logic [7:0] r_hold;

    // Cleared on every tick outside OPEN, so it is zero on entry to OPEN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold <= 8'd0;
        end else if (frame_tick) begin
            if (r_state != S_OPEN) begin
                r_hold <= 8'd0;
            end else if (!w_hold_done) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    assign w_hold_done = (r_hold == L_HOLD_LAST);
`else
    logic w_unused_hold_cfg;

    // HOLD_FRAMES only matters when the auto-close counter is built.
    assign w_unused_hold_cfg = (HOLD_FRAMES > 0);
    assign w_hold_done       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rows_nxt  = r_rows;
        w_exit_nxt  = 1'b0;
        if (frame_tick) begin
            case (r_state)
                S_LOCKED: begin
                    if (unlock) begin
                        w_state_nxt = S_CLOSED;
                    end
                end
                S_CLOSED: begin
                    if (!unlock) begin
                        w_state_nxt = S_LOCKED;
                    end else if (player_at_door) begin
                        w_state_nxt = S_OPENING;
                    end
                end
                S_OPENING: begin
                    if (!unlock) begin
                        w_state_nxt = S_CLOSING;
                    end else if (w_rows_up >= L_HEIGHT) begin
                        w_rows_nxt  = L_HEIGHT[6:0];
                        w_state_nxt = S_OPEN;
                    end else begin
                        w_rows_nxt = w_rows_up[6:0];
                    end
                end
                S_OPEN: begin
                    if (player_at_door) begin
                        w_state_nxt = S_EXITED;
                        w_exit_nxt  = 1'b1;
                    end else if (!unlock || close_req) begin
                        w_state_nxt = S_CLOSING;
                    end else if (w_hold_done) begin
                        w_state_nxt = S_CLOSING;
                    end
                end
                S_CLOSING: begin
                    if (unlock && player_at_door && !close_req) begin
                        w_state_nxt = S_OPENING;
                    end else if (w_rows8 <= L_STEP) begin
                        w_rows_nxt  = 7'd0;
                        w_state_nxt = unlock ? S_CLOSED : S_LOCKED;
                    end else begin
                        w_rows_nxt = w_rows_dn;
                    end
                end
                S_EXITED: begin
                    w_state_nxt = S_EXITED;
                end
                default: begin
                    w_state_nxt = S_LOCKED;
                    w_rows_nxt  = 7'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_LOCKED;
            r_rows   <= 7'd0;
            r_exit   <= 1'b0;
            r_locked <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_rows   <= w_rows_nxt;
            r_exit   <= w_exit_nxt;
            r_locked <= (w_state_nxt == S_LOCKED);
        end
    end

    assign state          = r_state;
    assign door_open_rows = r_rows;
    assign locked         = r_locked;
    assign exit_pulse     = r_exit;

endmodule

// File: tb/tb_door_sequencer.sv
// tb/tb_door_sequencer.sv - self-checking bench for door_sequencer (default and STEP=7/HOLD_FRAMES=3 instances)
module tb_door_sequencer;

    typedef struct packed {
        logic [31:0] st;
        logic [31:0] rows;
        logic [31:0] hold;
        logic        ex;
    } mdl_t;

`ifdef DOOR_AUTOCLOSE_EN
    localparam bit AC = 1'b1;
`else
    localparam bit AC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       unlock;
    logic       pad;
    logic       cr;

    logic [6:0] rows0, rows1;
    logic [2:0] st0, st1;
    logic       lk0, lk1, ex0, ex1;

    int   total = 0;
    int   bad   = 0;
    bit   check_en = 1'b0;
    mdl_t m [2];

    always #5 clk = ~clk;

    door_sequencer dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .unlock(unlock),
        .player_at_door(pad), .close_req(cr), .door_open_rows(rows0),
        .state(st0), .locked(lk0), .exit_pulse(ex0)
    );

    door_sequencer #(.DOOR_HEIGHT(80), .STEP(7), .HOLD_FRAMES(3)) dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .unlock(unlock),
        .player_at_door(pad), .close_req(cr), .door_open_rows(rows1),
        .state(st1), .locked(lk1), .exit_pulse(ex1)
    );

    // Door behaviour per frame tick, expressed as saturating row arithmetic.
    function automatic mdl_t model_next(input mdl_t c, input int h, input int s, input int hf,
                                        input bit ac, input bit rn, input bit ft,
                                        input bit un, input bit pd, input bit cq);
        mdl_t n;
        int   r;
        n    = c;
        n.ex = 1'b0;
        if (!rn) return '0;
        if (!ft) return n;
        r = int'(c.rows);
        case (int'(c.st))
            0: if (un) n.st = 1;
            1: if (!un) n.st = 0; else if (pd) n.st = 2;
            2: begin
                if (!un) n.st = 4;
                else begin
                    r = (r + s < h) ? r + s : h;
                    n.rows = 32'(r);
                    if (r == h) begin
                        n.st   = 3;
                        n.hold = 0;
                    end
                end
            end
            3: begin
                if (pd) begin
                    n.st = 5;
                    n.ex = 1'b1;
                end else if (!un || cq) n.st = 4;
                else if (ac) begin
                    if (int'(c.hold) + 1 >= hf) n.st = 4;
                    else n.hold = c.hold + 1;
                end
            end
            4: begin
                if (un && pd && !cq) n.st = 2;
                else begin
                    r = (r > s) ? r - s : 0;
                    n.rows = 32'(r);
                    if (r == 0) n.st = un ? 1 : 0;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m[0] <= model_next(m[0], 80, 4, 120, AC, rst, frame_tick, unlock, pad, cr);
        m[1] <= model_next(m[1], 80, 7, 3, AC, rst, frame_tick, unlock, pad, cr);
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model0_state", int'(st0), int'(m[0].st));
            check("model0_rows", int'(rows0), int'(m[0].rows));
            check("model0_exit", int'(ex0), int'(m[0].ex));
            check("model0_locked", int'(lk0), (m[0].st == 0) ? 1 : 0);
            check("model1_state", int'(st1), int'(m[1].st));
            check("model1_rows", int'(rows1), int'(m[1].rows));
            check("model1_exit", int'(ex1), int'(m[1].ex));
            check("model1_locked", int'(lk1), (m[1].st == 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; frame_tick = 1'b0; unlock = 1'b0; pad = 1'b0; cr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b1; unlock = 1'b1; pad = 1'b1; cr = 1'b0;

        // Reset wins over simultaneous frame ticks.
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("rst_state0", int'(st0), 0);
        check("rst_rows0", int'(rows0), 0);
        check("rst_exit0", int'(ex0), 0);
        check("rst_locked0", int'(lk0), 1);
        check("rst_state1", int'(st1), 0);
        frame_tick = 1'b0;
        rst = 1'b1;

        // Full exit with the player standing at the door.
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 1) begin
                check("exit_t1_state0", int'(st0), 1);
                check("exit_t1_locked0", int'(lk0), 0);
            end
            if (k == 2) begin
                check("exit_t2_state0", int'(st0), 2);
                check("exit_t2_rows0", int'(rows0), 0);
            end
            if (k == 3) check("exit_t3_rows0", int'(rows0), 4);
            if (k >= 3 && k <= 13) check($sformatf("sat7_open_t%0d", k), int'(rows1), 7 * (k - 2));
            if (k == 14) begin
                check("sat7_open_rows_top", int'(rows1), 80);
                check("sat7_open_state", int'(st1), 3);
            end
            if (k == 15) check("exit7_state", int'(st1), 5);
            if (k == 22) begin
                check("exit_t22_rows0", int'(rows0), 80);
                check("exit_t22_state0", int'(st0), 3);
            end
            if (k == 23) begin
                check("exit_t23_state0", int'(st0), 5);
                check("exit_t23_pulse0", int'(ex0), 1);
            end
        end
        @(negedge clk);
        check("exit_pulse_drop0", int'(ex0), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("exited_hold_state0", int'(st0), 5);
            check("exited_hold_rows0", int'(rows0), 80);
            check("exited_hold_rows1", int'(rows1), 80);
        end

        // Back-to-back ticks, then lock mid-open.
        do_reset();
        unlock = 1'b1; pad = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        frame_tick = 1'b0;
        check("b2b_state0", int'(st0), 2);
        check("b2b_rows0", int'(rows0), 4);
        check("b2b_rows1", int'(rows1), 7);
        pad = 1'b0;
        for (int k = 4; k <= 12; k++) tick();
        check("lock_pre_rows0", int'(rows0), 40);
        check("lock_pre_rows1", int'(rows1), 70);
        unlock = 1'b0;
        tick();
        check("lock_state0", int'(st0), 4);
        check("lock_rows0", int'(rows0), 40);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("lock_close_rows0_%0d", i), int'(rows0), 40 - 4 * i);
            check($sformatf("lock_close_state0_%0d", i), int'(st0), (i < 10) ? 4 : 0);
        end
        check("lock_end_rows1", int'(rows1), 0);
        check("lock_end_state1", int'(st1), 0);

        // Auto-close (or its absence) and saturating close from 80 with STEP=7.
        do_reset();
        unlock = 1'b1; pad = 1'b1;
        tick();
        tick();
        pad = 1'b0;
        for (int k = 3; k <= 14; k++) tick();
        check("hold_enter_state1", int'(st1), 3);
        check("hold_enter_rows1", int'(rows1), 80);
`ifdef DOOR_AUTOCLOSE_EN
        tick();
        check("ac_t1_state1", int'(st1), 3);
        tick();
        check("ac_t2_state1", int'(st1), 3);
        tick();
        check("ac_t3_state1", int'(st1), 4);
        check("ac_t3_rows1", int'(rows1), 80);
`else
        for (int k = 0; k < 200; k++) begin
            tick();
            if (k == 100) begin
                pad = 1'b1;
                @(negedge clk);
                pad = 1'b0;
            end
        end
        check("noac_state1", int'(st1), 3);
        check("noac_state0", int'(st0), 3);
        cr = 1'b1;
        tick();
        check("creq_state1", int'(st1), 4);
        check("creq_rows1", int'(rows1), 80);
`endif
        for (int i = 1; i <= 11; i++) begin
            tick();
            check($sformatf("sat7_close_rows_%0d", i), int'(rows1), 80 - 7 * i);
        end
        tick();
        check("sat7_close_rows_end", int'(rows1), 0);
        check("sat7_close_state_end", int'(st1), 1);
        cr = 1'b0;

        // Reversal while closing, then reset mid-animation with a tick.
        do_reset();
        unlock = 1'b1; pad = 1'b1;
        tick();
        tick();
        pad = 1'b0;
        for (int k = 3; k <= 14; k++) tick();
        unlock = 1'b0;
        tick();
        check("rev_close_rows0", int'(rows0), 48);
        unlock = 1'b1;
        tick();
        tick();
        check("rev_pre_state0", int'(st0), 4);
        check("rev_pre_rows0", int'(rows0), 40);
        pad = 1'b1;
        tick();
        check("rev_state0", int'(st0), 2);
        check("rev_rows0", int'(rows0), 40);
        tick();
        check("rev_next_rows0", int'(rows0), 44);
        @(negedge clk);
        rst = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        check("mid_rst_state0", int'(st0), 0);
        check("mid_rst_rows0", int'(rows0), 0);
        check("mid_rst_locked0", int'(lk0), 1);
        rst = 1'b1;
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
